// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V subset controller (addi, lw, bne).
// Moore-decoded controls, with a per-wait-state memory timeout that traps the core.
module multicycle_ctrl #(
  parameter int OPCODE_WIDTH = 7,
  parameter int ALU_WIDTH    = 2,
  parameter int IMM_WIDTH    = 3,
  parameter int TIMEOUT      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [2:0]              funct3,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_addr_sel,
  output logic                    ir_we,
  output logic                    pc_we,
  output logic                    pc_src,
  output logic                    alu_src,
  output logic [ALU_WIDTH-1:0]    alu_ctrl,
  output logic [IMM_WIDTH-1:0]    imm_src,
  output logic                    reg_we,
  output logic                    result_src,
  output logic                    halt,
  output logic [1:0]              trap_cause,
  output logic [31:0]             retired
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB_ALU, WB_MEM, BRANCH, TRAP
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(7'b1100011);
  localparam logic [7:0]              LIMIT   = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [7:0] wait_cnt;
  logic       is_load;
  logic [1:0] cause_n;
  logic       timeout;

  assign timeout = (wait_cnt == LIMIT) && !mem_ready;

  // State, wait counter, load flag, trap cause and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      wait_cnt   <= '0;
      is_load    <= 1'b0;
      trap_cause <= 2'd0;
      retired    <= '0;
    end else begin
      state      <= state_n;
      trap_cause <= cause_n;
      if (state_n != state)
        wait_cnt <= '0;
      else if ((state == FETCH || state == MEM) && !mem_ready)
        wait_cnt <= wait_cnt + 8'd1;
      if (state == DECODE)
        is_load <= (opcode == OP_LW);
      if (state == WB_ALU || state == WB_MEM || state == BRANCH)
        retired <= retired + 32'd1;
    end
  end

  always_comb begin
    state_n = state;
    cause_n = trap_cause;
    case (state)
      FETCH:
        if (mem_ready) state_n = DECODE;
        else if (timeout) begin state_n = TRAP; cause_n = 2'd2; end
      DECODE:
        if ((opcode == OP_ADDI && funct3 == 3'b000) ||
            (opcode == OP_LW   && funct3 == 3'b010))
          state_n = EXEC;
        else if (opcode == OP_BNE && funct3 == 3'b001)
          state_n = BRANCH;
        else begin
          state_n = TRAP;
          cause_n = 2'd1;
        end
      EXEC:    state_n = is_load ? MEM : WB_ALU;
      MEM:
        if (mem_ready) state_n = WB_MEM;
        else if (timeout) begin state_n = TRAP; cause_n = 2'd2; end
      WB_ALU, WB_MEM, BRANCH: state_n = FETCH;
      TRAP:    state_n = TRAP;
      default: state_n = FETCH;
    endcase
  end

  // Only ir_we/pc_we in FETCH and pc_we in BRANCH look at inputs
  always_comb begin
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    alu_src      = 1'b0;
    alu_ctrl     = ALU_WIDTH'(0);
    imm_src      = IMM_WIDTH'(0);
    reg_we       = 1'b0;
    result_src   = 1'b0;
    halt         = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
      end
      EXEC: alu_src = 1'b1;
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
      end
      WB_ALU: reg_we = 1'b1;
      WB_MEM: begin
        reg_we     = 1'b1;
        result_src = 1'b1;
      end
      BRANCH: begin
        alu_ctrl = ALU_WIDTH'(1);
        imm_src  = IMM_WIDTH'(3);
        pc_src   = 1'b1;
        pc_we    = !zero;
      end
      TRAP:    halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-002 Parameter OPCODE_WIDTH, 7, SHALL set the opcode field width.
REQ-003 Parameter ALU_WIDTH, 2, SHALL set the alu_ctrl width (Sum=0, Sub=1, And=2).
REQ-004 Parameter IMM_WIDTH, 3, SHALL set the imm_src width (Imm=0, UpperImm=1, Store=2, Branch=3, Jump=4).
REQ-005 Parameter TIMEOUT, 16, SHALL set the maximum memory wait in cycles (range 1..255).
REQ-006 The ports SHALL be:
  clk  in  1  rising-edge clock
  rst_n  in  1  async active-low reset
  opcode  in  OPCODE_WIDTH  IR[6:0]
  funct3  in  3  IR[14:12]
  zero  in  1  ALU result == 0
  mem_ready  in  1  memory accepts/completes current request this cycle
  mem_req  out  1  memory request
  mem_addr_sel  out  1  0=PC, 1=ALU result register
  ir_we  out  1  latch IR and old_pc
  pc_we  out  1  PC write enable
  pc_src  out  1  0=PC+4, 1=old_pc+imm
  alu_src  out  1  0=rs2, 1=immediate
  alu_ctrl  out  ALU_WIDTH  ALU operation
  imm_src  out  IMM_WIDTH  immediate format
  reg_we  out  1  register file write enable
  result_src  out  1  0=ALU, 1=memory data
  halt  out  1  controller trapped
  trap_cause  out  2  0=none, 1=illegal, 2=timeout
  retired  out  32  retired instruction count

Function
REQ-007 The FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB_ALU, WB_MEM, BRANCH and TRAP.
REQ-008 The block SHALL be Moore-style: outputs decode from the registered state only, except pc_we and ir_we in FETCH and pc_we in BRANCH.
REQ-009 In FETCH, mem_req=1 and mem_addr_sel=0; on mem_ready=1, ir_we=1, pc_we=1 and pc_src=0 that cycle, and the next state is DECODE.
REQ-010 DECODE SHALL last one cycle: addi (0010011) with funct3=000 -> EXEC; lw (0000011) with funct3=010 -> EXEC; bne (1100011) with funct3=001 -> BRANCH; anything else -> TRAP with trap_cause=1.
REQ-011 In EXEC, alu_ctrl=Sum, alu_src=1 and imm_src=Imm; the next state is WB_ALU for addi and MEM for lw.
REQ-012 In MEM, mem_req=1 and mem_addr_sel=1; on mem_ready=1 the next state is WB_MEM.
REQ-013 WB_ALU SHALL drive reg_we=1 and result_src=0; WB_MEM SHALL drive reg_we=1 and result_src=1; both SHALL go to FETCH and increment retired.
REQ-014 In BRANCH, alu_ctrl=Sub, alu_src=0 and imm_src=Branch; if zero=0, pc_we=1 and pc_src=1; the next state is FETCH and retired SHALL increment.
REQ-015 An 8-bit wait counter SHALL clear on every state change and increment each FETCH/MEM cycle with mem_ready=0; when it reaches TIMEOUT-1 with mem_ready still 0, the next state is TRAP with trap_cause=2.
REQ-016 A mem_ready in the same cycle the counter hits its limit SHALL take priority: normal transition, no trap.
REQ-017 TRAP SHALL be absorbing: halt=1, all enables and mem_req 0, and trap_cause held until reset.
REQ-018 Outside the states named above, all enables, mem_req, pc_src, alu_src, mem_addr_sel and result_src SHALL be 0, with alu_ctrl=Sum and imm_src=Imm.
REQ-019 retired SHALL wrap modulo 2^32.
REQ-020 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-021 With zero-wait memory, latency SHALL be bne 3, addi 4 and lw 5 cycles from FETCH entry to next FETCH entry.

Reset
REQ-022 rst_n=0 SHALL immediately force state FETCH, wait counter 0, retired 0, trap_cause 0 and halt 0, asynchronously and even mid-MEM or in TRAP.
REQ-023 After rst_n deasserts, the first rising edge SHALL evaluate FETCH normally, with mem_req=1 visible during reset release.

Verification
REQ-024 addi x1,x0,5 (opcode 0010011, funct3 000), mem_ready always 1 -> state trace FETCH, DECODE, EXEC, WB_ALU; reg_we=1 in cycle 4; retired=1.
REQ-025 lw (0000011/010) with MEM mem_ready delayed 3 cycles -> mem_req held 4 MEM cycles with mem_addr_sel=1; WB_MEM gives result_src=1; retired=1.
REQ-026 bne (1100011/001): zero=0 gives pc_we=1 and pc_src=1 in BRANCH; zero=1 gives pc_we=0; retired increments in both cases.
REQ-027 Opcode 0110111, or addi with funct3=111 -> TRAP after DECODE, halt=1, trap_cause=1; further mem_ready pulses have no effect.
REQ-028 TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP entered after 4 FETCH cycles with trap_cause=2; a separate run with mem_ready=1 on cycle 4 -> DECODE, no trap.
REQ-029 rst_n pulsed low mid-MEM after 10 retirements -> outputs reset asynchronously, retired=0, state FETCH.
